// File: rtl/contador_pkg.sv
// contador_pkg: mode encodings and default sizing shared by the counter files
package contador_pkg;
    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_STEP = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;
    localparam int DEF_WIDTH = 32;
    localparam longint unsigned DEF_STEP = 3;
endpackage

// File: rtl/contador_param_if.sv
// contador_param_if: control inputs and registered outputs of the counter
interface contador_param_if
    import contador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             enable;
    mode_t            mode;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q = '0;
    logic             rco = 1'b0;
    logic             load = 1'b0;
    modport master (output enable, mode, D, input Q, rco, load);
    modport slave  (input enable, mode, D, output Q, rco, load);
endinterface

// File: rtl/contador_step_unit.sv
// contador_step_unit: next count and overflow/underflow flag for one enabled step
module contador_step_unit
    import contador_pkg::*;
#(
    parameter int              WIDTH    = DEF_WIDTH,
    parameter longint unsigned STEP     = DEF_STEP,
    parameter bit              SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt,
    output logic             flag
);
    localparam logic [WIDTH:0] STEP_V = (WIDTH+1)'(STEP);
    logic [WIDTH:0]   up;
    logic [WIDTH-1:0] wrap;
    always_comb begin
        up   = {1'b0, q} + (mode == MODE_STEP ? STEP_V : (WIDTH+1)'(1));
        wrap = mode == MODE_LOAD ? d : mode == MODE_DOWN ? q - 1'b1 : up[WIDTH-1:0];
        flag = mode == MODE_LOAD ? 1'b0 : mode == MODE_DOWN ? (q == '0) : up[WIDTH];
        // clamp to the bound in the direction of travel
        nxt  = (SATURATE && flag) ? (mode == MODE_DOWN ? '0 : '1) : wrap;
    end
endmodule

// File: rtl/contador_param.sv
// contador_param: registered up/down/step/load counter with wrap or clamp policy
module contador_param
    import contador_pkg::*;
#(
    parameter int              WIDTH    = DEF_WIDTH,
    parameter longint unsigned STEP     = DEF_STEP,
    parameter bit              SATURATE = 1'b0
) (
    input logic             clk,
    input logic             reset,
    contador_param_if.slave bus
);
    logic [WIDTH-1:0] nxt;
    logic             flag;
    contador_step_unit #(.WIDTH(WIDTH), .STEP(STEP), .SATURATE(SATURATE)) u_step (
        .q(bus.Q), .mode(bus.mode), .d(bus.D), .nxt(nxt), .flag(flag)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Q    <= '0;
            bus.rco  <= 1'b0;
            bus.load <= 1'b0;
        end else if (!bus.enable) begin
            bus.rco  <= 1'b0;
            bus.load <= 1'b0;
        end else begin
            bus.Q    <= nxt;
            bus.rco  <= flag;
            bus.load <= bus.mode == MODE_LOAD;
        end
    end
endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 32, counter width in bits, legal range 2..64.
REQ-002 Parameter STEP, default 3, increment used in mode 2'b10, legal range 1..2^WIDTH-1.
REQ-003 Parameter SATURATE, default 0, selects overflow policy: 0 = wrap, 1 = clamp at the bound.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  step/load qualifier; no state change except flag clearing when low.
REQ-007 mode  input  2  operation: 00 up by 1, 01 down by 1, 10 up by STEP, 11 parallel load.
REQ-008 D  input  WIDTH  parallel load value, used only in mode 11.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 rco  output  1  registered carry/borrow-out pulse.
REQ-011 load  output  1  registered pulse, high for the cycle after a load.

Function
REQ-012 All outputs SHALL be registered, with 1-cycle latency from a sampled edge to the visible Q/rco/load.
REQ-013 Priority SHALL be: reset > enable low > mode.
REQ-014 With enable=0, Q SHALL hold and rco and load SHALL be 0 on the next cycle.
REQ-015 Mode 00 SHALL compute Q+1 in WIDTH+1 bits; bit WIDTH set is an overflow.
REQ-016 Mode 01 SHALL compute Q-1; Q==0 before the step is an underflow.
REQ-017 Mode 10 SHALL compute Q+STEP in WIDTH+1 bits; bit WIDTH set is an overflow, including overshoot past all-ones (not only exact hits).
REQ-018 Mode 11 SHALL set Q=D, load=1 and rco=0.
REQ-019 In modes 00/01/10, load SHALL be 0.
REQ-020 In modes 00/01/10, rco SHALL be 1 exactly for the cycle whose Q results from an overflow/underflow, and 0 otherwise.
REQ-021 On overflow/underflow with SATURATE=0, Q SHALL take the low WIDTH bits of the result (modular wrap).
REQ-022 With SATURATE=1, overflow SHALL set Q=2^WIDTH-1 and underflow SHALL set Q=0, with rco=1 on every enabled step that would overflow/underflow, including repeated steps at the bound.
REQ-023 A mode change between cycles SHALL take effect on the next enabled edge with no extra latency or bubble.
REQ-024 Q SHALL power up as 0 in simulation.

Reset
REQ-025 reset=1 at a rising edge SHALL force Q=0, rco=0 and load=0 regardless of enable, mode or D.
REQ-026 Reset asserted mid-operation (any mode, enable=1) SHALL discard the pending step or load entirely.
REQ-027 The first enabled edge after reset deasserts SHALL operate normally from Q=0.

Structure
REQ-028 Package contador_pkg SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_STEP, MODE_LOAD) and the default WIDTH/STEP constants.
REQ-029 Sub-module contador_step_unit (combinational) SHALL compute next value and overflow/underflow flag from Q, mode, D, STEP and SATURATE.
REQ-030 The top level SHALL contain only the output registers and the priority logic.

Verification (WIDTH=8, STEP=3 unless stated)
REQ-031 Reset, then mode 00 with enable=1 for 255 edges -> Q=0xFF with rco=0; next edge -> Q=0x00, rco=1 for one cycle; following edge -> Q=0x01, rco=0.
REQ-032 Mode 11 with D=0xFE -> Q=0xFE, load=1; then mode 10 -> Q=0x01, rco=1, load=0.
REQ-033 Q=0x00, mode 01 -> Q=0xFF, rco=1; next edge -> Q=0xFE, rco=0.
REQ-034 SATURATE=1, Q=0xFE, mode 10 for 2 edges -> Q=0xFF, rco=1 on both; Q=0x01, mode 01 for 2 edges -> Q=0x00, rco=0 then rco=1.
REQ-035 Q=0x40, mode 11, D=0x99, enable=1, reset=1 on the same edge -> Q=0x00, load=0, rco=0.
REQ-036 Q=0x7F, enable=0 for 3 edges with all modes cycled -> Q stays 0x7F, rco=0, load=0.
